// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
package pc_pkg;

   // Next-PC source, listed in priority order.
   typedef enum logic [2:0] {
      PC_RST,
      PC_EXC,
      PC_HOLD,
      PC_REDIR,
      PC_PEND,
      PC_SEQ
   } pc_sel_t;

   // Default vectors for a 32-bit datapath.
   localparam int unsigned DEF_W         = 32;
   localparam int unsigned DEF_INC       = 4;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

   // A target is aligned when its low log2(inc) bits are zero; inc is a power
   // of two, so inc-1 is exactly that bit mask (empty for inc=1).
   function automatic logic is_aligned(input logic [63:0] target, input int unsigned inc);
      return (target & (64'(inc) - 64'd1)) == 64'd0;
   endfunction

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// One-entry redirect target buffer with capture, clear and consume controls.
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         capture_i,
   input  logic [W-1:0] target_i,
   input  logic         clear_i,
   input  logic         consume_i,
   output logic         valid_o,
   output logic [W-1:0] target_o
);

   logic         valid_q;
   logic [W-1:0] target_q;

   // Clear dominates capture, capture dominates consume.
   // NOTE: the stored target is reset too so a stale value can never leak out
   // after reset; clocked state is always assigned with <= so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         target_q <= '0;
      end else if (clear_i) begin
         valid_q  <= 1'b0;
      end else if (capture_i) begin
         valid_q  <= 1'b1;
         target_q <= target_i;
      end else if (consume_i) begin
         valid_q  <= 1'b0;
      end
   end

   assign valid_o  = valid_q;
   assign target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, stall hold, redirect,
// buffered redirect and exception vectoring, with flush/misalign pulses.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned W         = DEF_W,
   parameter int unsigned INC       = DEF_INC,
   parameter logic [W-1:0] RESET_VEC = W'(DEF_RESET_VEC),
   parameter logic [W-1:0] EXC_VEC   = W'(DEF_EXC_VEC)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         redir_valid,
   input  logic [W-1:0] redir_target,
   input  logic         exc_valid,
   output logic [W-1:0] pc,
   output logic         pc_valid,
   output logic         flush,
   output logic         pend,
   output logic         misalign
);

   logic [W-1:0] pc_q, pc_d;
   logic         pc_valid_q;
   logic         flush_q, flush_d;
   logic         misalign_q, misalign_d;
   pc_sel_t      sel;
   logic         redir_misaligned;
   logic [W-1:0] redir_eff;
   logic         buf_valid;
   logic [W-1:0] buf_target;

   // A misaligned redirect is replaced by the exception vector.
   assign redir_misaligned = redir_valid && !is_aligned(64'(redir_target), INC);
   assign redir_eff        = redir_misaligned ? EXC_VEC : redir_target;

   // Pick the next-PC source; first matching condition wins.
   // NOTE: sel gets a default before the if-chain so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      sel = PC_SEQ;
      if (reset)            sel = PC_RST;
      else if (exc_valid)   sel = PC_EXC;
      else if (stall)       sel = PC_HOLD;
      else if (redir_valid) sel = PC_REDIR;
      else if (buf_valid)   sel = PC_PEND;
   end

   // Next-state values derived from the selected source.
   always_comb begin
      pc_d = pc_q + W'(INC);
      unique case (sel)
         PC_RST:   pc_d = RESET_VEC;
         PC_EXC:   pc_d = EXC_VEC;
         PC_HOLD:  pc_d = pc_q;
         PC_REDIR: pc_d = redir_eff;
         PC_PEND:  pc_d = buf_target;
         PC_SEQ:   pc_d = pc_q + W'(INC);
         default:  pc_d = pc_q + W'(INC);
      endcase
      flush_d    = (sel == PC_EXC) || (sel == PC_REDIR) || (sel == PC_PEND);
      // An exception discards the incoming redirect, so it raises no misalign.
      misalign_d = redir_misaligned && !exc_valid && !reset;
   end

   // Single registered update of the PC and its status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_VEC;
         pc_valid_q <= 1'b0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_valid_q <= 1'b1;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end

   pc_redirect_buf #(.W(W)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .capture_i (sel == PC_HOLD && redir_valid),
      .target_i  (redir_eff),
      .clear_i   (exc_valid),
      .consume_i ((sel == PC_REDIR) || (sel == PC_PEND)),
      .valid_o   (buf_valid),
      .target_o  (buf_target)
   );

   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;
   assign flush    = flush_q;
   assign pend     = buf_valid;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench: three pc_gen configurations share one input stream
// and are compared every cycle against a behavioural model.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_target = '0;
   logic        exc_valid = 1'b0;

   logic [31:0] pc_a, pc_b;
   logic [7:0]  pc_c;
   logic [2:0]  valid_o, flush_o, pend_o, mis_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // a: W=32 INC=4, b: W=32 INC=1, c: W=8 INC=4
   pc_gen #(.W(32), .INC(4), .RESET_VEC(32'h0), .EXC_VEC(32'h80)) dut_a (
      .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
      .redir_target(redir_target), .exc_valid(exc_valid), .pc(pc_a),
      .pc_valid(valid_o[0]), .flush(flush_o[0]), .pend(pend_o[0]), .misalign(mis_o[0]));

   pc_gen #(.W(32), .INC(1), .RESET_VEC(32'h0), .EXC_VEC(32'h80)) dut_b (
      .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
      .redir_target(redir_target), .exc_valid(exc_valid), .pc(pc_b),
      .pc_valid(valid_o[1]), .flush(flush_o[1]), .pend(pend_o[1]), .misalign(mis_o[1]));

   pc_gen #(.W(8), .INC(4), .RESET_VEC(8'h0), .EXC_VEC(8'h80)) dut_c (
      .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
      .redir_target(redir_target[7:0]), .exc_valid(exc_valid), .pc(pc_c),
      .pc_valid(valid_o[2]), .flush(flush_o[2]), .pend(pend_o[2]), .misalign(mis_o[2]));

   // Reference model state per configuration.
   longint unsigned m_inc[3] = '{4, 1, 4};
   longint unsigned m_mod[3] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'h100};
   longint unsigned m_exc[3] = '{64'h80, 64'h80, 64'h80};
   longint unsigned m_pc[3];
   longint unsigned m_buf[3];
   bit m_valid[3], m_flush[3], m_pend[3], m_mis[3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply the next-PC rules to the model for the inputs present at this edge.
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         longint unsigned tgt = longint'(redir_target) % m_mod[i];
         bit bad = (tgt % m_inc[i]) != 0;
         longint unsigned eff = bad ? m_exc[i] : tgt;
         if (reset) begin
            m_pc[i] = 0; m_valid[i] = 0; m_flush[i] = 0; m_pend[i] = 0; m_mis[i] = 0; m_buf[i] = 0;
         end else begin
            m_valid[i] = 1;
            m_mis[i]   = redir_valid && !exc_valid && bad;
            m_flush[i] = 0;
            if (exc_valid) begin
               m_pc[i] = m_exc[i]; m_pend[i] = 0; m_flush[i] = 1;
            end else if (stall && redir_valid) begin
               m_buf[i] = eff; m_pend[i] = 1;
            end else if (stall) begin
               // hold
            end else if (redir_valid) begin
               m_pc[i] = eff; m_pend[i] = 0; m_flush[i] = 1;
            end else if (m_pend[i]) begin
               m_pc[i] = m_buf[i]; m_pend[i] = 0; m_flush[i] = 1;
            end else begin
               m_pc[i] = (m_pc[i] + m_inc[i]) % m_mod[i];
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] obs_pc[3];
      obs_pc[0] = pc_a; obs_pc[1] = pc_b; obs_pc[2] = {24'h0, pc_c};
      for (int i = 0; i < 3; i++) begin
         check($sformatf("pc[%0d]", i), obs_pc[i], 32'(m_pc[i]));
         check($sformatf("pc_valid[%0d]", i), 32'(valid_o[i]), 32'(m_valid[i]));
         check($sformatf("flush[%0d]", i), 32'(flush_o[i]), 32'(m_flush[i]));
         check($sformatf("pend[%0d]", i), 32'(pend_o[i]), 32'(m_pend[i]));
         check($sformatf("misalign[%0d]", i), 32'(mis_o[i]), 32'(m_mis[i]));
      end
   endtask

   task automatic tick();
      assert (!$isunknown({reset, stall, redir_valid, exc_valid}))
         else $error("FAIL input_x observed=%b expected=known", {reset, stall, redir_valid, exc_valid});
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic redir(input logic [31:0] t);
      redir_valid = 1'b1;
      redir_target = t;
   endtask

   initial begin
      // Reset, then sequential run.
      reset = 1'b1;
      tick(); tick();
      check("reset_pc", pc_a, 32'h0);
      check("reset_valid", 32'(valid_o[0]), 32'h0);
      reset = 1'b0;
      tick(); check("seq1", pc_a, 32'h4);
      check("valid_after_reset", 32'(valid_o[0]), 32'h1);
      tick(); check("seq2", pc_a, 32'h8);
      tick(); check("seq3", pc_a, 32'hC);
      tick(); check("seq4", pc_a, 32'h10);

      // Redirect while stalled is buffered, then applied when stall drops.
      stall = 1'b1; redir(32'h200);
      tick();
      redir_valid = 1'b0;
      tick(); check("stall_hold", pc_a, 32'h10); check("stall_pend", 32'(pend_o[0]), 32'h1);
      stall = 1'b0;
      tick(); check("pend_load", pc_a, 32'h200); check("pend_flush", 32'(flush_o[0]), 32'h1);
      check("pend_clear", 32'(pend_o[0]), 32'h0);
      tick(); check("after_pend", pc_a, 32'h204); check("flush_drop", 32'(flush_o[0]), 32'h0);

      // Exception beats stall and pending redirect.
      stall = 1'b1; redir(32'h300);
      tick();
      redir_valid = 1'b0; exc_valid = 1'b1;
      tick(); check("exc_pc", pc_a, 32'h80); check("exc_pend", 32'(pend_o[0]), 32'h0);
      check("exc_flush", 32'(flush_o[0]), 32'h1);
      exc_valid = 1'b0;
      tick(); check("exc_hold", pc_a, 32'h80);
      stall = 1'b0;
      tick(); check("exc_seq", pc_a, 32'h84);

      // Misaligned redirect.
      redir(32'h102);
      tick(); check("mis_pc_a", pc_a, 32'h80); check("mis_a", 32'(mis_o[0]), 32'h1);
      check("mis_pc_b", pc_b, 32'h102); check("mis_b", 32'(mis_o[1]), 32'h0);
      redir_valid = 1'b0;
      tick(); check("mis_pulse_end", 32'(mis_o[0]), 32'h0);

      // Wrap-around on the 8-bit instance.
      redir(32'hFC);
      tick();
      redir_valid = 1'b0;
      tick(); check("wrap_c", {24'h0, pc_c}, 32'h0); check("nowrap_a", pc_a, 32'h100);

      // Fresh redirect beats a buffered one.
      stall = 1'b1; redir(32'h40);
      tick();
      stall = 1'b0; redir(32'h60);
      tick(); check("fresh_wins", pc_a, 32'h60); check("fresh_pend", 32'(pend_o[0]), 32'h0);
      redir_valid = 1'b0;

      // Reset mid-stall with a buffered redirect.
      stall = 1'b1; redir(32'h300);
      tick();
      redir_valid = 1'b0; reset = 1'b1;
      tick(); check("rst_pc", pc_a, 32'h0); check("rst_pend", 32'(pend_o[0]), 32'h0);
      check("rst_flush", 32'(flush_o[0]), 32'h0); check("rst_valid", 32'(valid_o[0]), 32'h0);
      reset = 1'b0; stall = 1'b0;
      tick(); check("rst_no_pend", pc_a, 32'h4);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(99) == 0);
         stall        = ($urandom_range(9) < 3);
         exc_valid    = ($urandom_range(19) == 0);
         redir_valid  = ($urandom_range(3) == 0);
         redir_target = $urandom();
         if ($urandom_range(3) != 0) redir_target[1:0] = 2'b00;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the pipelined datapath's fetch stage.
- Holds the PC, advances it by a fixed increment, holds on stall, and loads redirect or exception targets.
- A one-entry pending buffer keeps a redirect that arrives while fetch is stalled, so it is never lost.
- All state changes are synchronous to clk. There are no level-sensitive updates and the PC is never driven to X.
- Emits a one-cycle flush pulse to squash younger IF/ID contents after any non-sequential load.

Parameters:
W, 32, PC width in bits.
INC, 4, sequential increment; power of two, at least 1.
RESET_VEC, 0, PC value loaded on reset (W bits).
EXC_VEC, 32'h0000_0080, exception/misalign handler address (W bits).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  1 = hold PC (hazard stall).
redir_valid  in  1  branch/jump taken this cycle.
redir_target  in  W  redirect destination.
exc_valid  in  1  exception request; never stalled.
pc  out  W  current fetch address (registered).
pc_valid  out  1  0 in the first cycle after reset, else 1.
flush  out  1  one-cycle pulse: pc was loaded non-sequentially on the previous edge.
pend  out  1  a redirect is buffered (registered).
misalign  out  1  one-cycle pulse: a redirect target was not INC-aligned.

Behaviour:
- Reset value of every output, set while reset=1 at a clk edge:
  - pc=RESET_VEC, pc_valid=0, flush=0, pend=0, misalign=0.
  - The buffer target is cleared to 0.
- pc_valid rises to 1 on the first edge with reset=0 and stays 1 until the next reset.
- Alignment rule: a target is misaligned when its low log2(INC) bits are not zero. For INC=1 no target is ever misaligned.
- Effective redirect: when misaligned, the target is replaced by EXC_VEC and misalign pulses on the next edge.
- Next-PC selection at each edge, first match wins:
  1. reset: RESET_VEC.
  2. exc_valid=1: EXC_VEC, regardless of stall. Clears pend and any incoming redirect. flush=1.
  3. stall=1 and redir_valid=1: pc holds. The buffer captures the effective target (overwriting an older one) and pend=1.
  4. stall=1: pc holds. Buffer unchanged.
  5. redir_valid=1 (not stalled): effective target is loaded. pend cleared. flush=1. A fresh redirect beats a buffered one.
  6. pend=1 (not stalled): buffered target is loaded, pend=0, flush=1.
  7. Otherwise: pc = pc + INC, modulo 2^W. Wrap-around is silent.
- Latency: redirect to pc is 1 cycle when not stalled. A buffered redirect is applied on the first edge with stall=0.
- flush is registered: it is 1 in the cycle immediately after a load by rule 2, 5 or 6, and 0 otherwise.
- misalign pulses even when the misaligned redirect is being buffered.
- Reset mid-stall with pend=1: buffer discarded, pc=RESET_VEC.
- Inputs are assumed known. An X on stall, redir_valid or exc_valid is a bench assertion error; the RTL has no X-special-casing.

Decomposition:
- Shared package pc_pkg:
  - enum pc_sel_t {PC_RST, PC_EXC, PC_HOLD, PC_REDIR, PC_PEND, PC_SEQ}.
  - Default-vector localparams.
  - Function is_aligned(target, INC).
- pc_gen computes pc_sel_t combinationally, then performs a single registered update.
- One sub-module, pc_redirect_buf: the one-entry target and valid register with capture, clear and consume controls. It is reusable for the branch-predictor redirect path.

Test Plan:
- Reset then run, W=32, INC=4: reset for 2 cycles -> pc=0 and pc_valid=0. Then pc=4, 8, 12 on successive edges, pc_valid=1 from the first post-reset cycle, flush=0 throughout.
- Redirect while stalled: pc=0x10; stall=1 with redir 0x200 in cycle n and stall still 1 at n+1 -> pc stays 0x10 and pend=1. stall=0 at n+2 -> pc=0x200 next edge, flush=1 the cycle after, pend=0; then pc=0x204.
- Exception beats stall and pend: pend=1 (target 0x300), stall=1, exc_valid=1 -> pc=0x80, pend=0, flush=1; then pc=0x84 once stall drops.
- Misaligned redirect: redir_target=0x102, not stalled -> pc=0x80 and misalign=1 for exactly one cycle. Repeat with INC=1 -> pc=0x102, misalign=0.
- Wrap and simultaneous events: W=8, INC=4, pc=0xFC -> pc=0x00. pend=1 (target 0x40) and fresh redir 0x60 with stall=0 -> pc=0x60 and pend=0.
- Reset mid-operation: pend=1 and stall=1, assert reset -> pc=RESET_VEC, pend=0, flush=0, pc_valid=0. No buffered target is applied after reset releases.
